// File: rtl/h_pair_sched.sv
// h_pair_sched: sequencer in front of a combinational single-qubit H butterfly.
// On start it latches a target qubit t and walks every amplitude pair
// (i0, i1 = i0 | 1<<t) of the state-vector RAM. For each pair it reads both
// words, holds them on the butterfly inputs, and writes the results back in place.
// RAM words are {real[31:16], imag[15:0]} in Q1.15; data passes through bit-exact.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, target             command strobe and target index (sampled in IDLE)
//   busy, done, err           pass status; err pulses with done on a bad target
//   rd_en, rd_addr, rd_data   RAM read port (data returns one cycle after rd_en)
//   wr_en, wr_addr, wr_data   RAM write port
//   g_ar/g_ai/g_br/g_bi       registered butterfly inputs (a = amp[i0], b = amp[i1])
//   g_out0r/i, g_out1r/i      butterfly results, combinational from g_*
module h_pair_sched #(
  parameter int N_QUBITS = 4,
  parameter int AW       = N_QUBITS,
  parameter int TW       = (N_QUBITS > 1) ? $clog2(N_QUBITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW-1:0] target,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [15:0]   g_ar,
  output logic [15:0]   g_ai,
  output logic [15:0]   g_br,
  output logic [15:0]   g_bi,
  input  logic [15:0]   g_out0r,
  input  logic [15:0]   g_out0i,
  input  logic [15:0]   g_out1r,
  input  logic [15:0]   g_out1i
);

  // Index of the last pair: P-1 with P = 2^(N_QUBITS-1).
  localparam logic [AW-1:0] KLAST = AW'((1 << (N_QUBITS - 1)) - 1);

  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, WR0, WR1, DONE} state_t;

  state_t        state, state_n;
  logic [AW-1:0] k;
  logic [TW-1:0] tgt;
  logic          bad;
  logic          invalid;
  logic [AW-1:0] lo_mask, i0, i1;

  assign invalid = (int'(target) >= N_QUBITS);

  // i0 = k with a zero spliced in at bit tgt: bits below tgt stay, bits at and
  // above tgt move up by one. k < P so the shifted-out top bit is always zero.
  assign lo_mask = (AW'(1) << tgt) - AW'(1);
  assign i0      = ((k & ~lo_mask) << 1) | (k & lo_mask);
  assign i1      = i0 | (AW'(1) << tgt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      tgt   <= '0;
      bad   <= 1'b0;
      g_ar  <= '0;
      g_ai  <= '0;
      g_br  <= '0;
      g_bi  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          tgt <= target;
          bad <= invalid;
          k   <= '0;
        end
        // rd_data lags rd_en by one cycle: amp[i0] is on the bus during RD1,
        // amp[i1] during CAP. g_* then hold steady through WR1.
        RD1: {g_ar, g_ai} <= rd_data;
        CAP: {g_br, g_bi} <= rd_data;
        WR1: if (k != KLAST) k <= k + AW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = 1'b0;
    err     = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      IDLE: if (start) state_n = invalid ? DONE : RD0;
      RD0: begin
        rd_en   = 1'b1;
        rd_addr = i0;
        state_n = RD1;
      end
      RD1: begin
        rd_en   = 1'b1;
        rd_addr = i1;
        state_n = CAP;
      end
      CAP: state_n = WR0;
      WR0: begin
        wr_en   = 1'b1;
        wr_addr = i0;
        wr_data = {g_out0r, g_out0i};
        state_n = WR1;
      end
      WR1: begin
        wr_en   = 1'b1;
        wr_addr = i1;
        wr_data = {g_out1r, g_out1i};
        state_n = (k == KLAST) ? DONE : RD0;
      end
      DONE: begin
        done    = 1'b1;
        err     = bad;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_h_pair_sched.sv
// Bench for h_pair_sched: a 2-qubit instance with a RAM model and a true H
// butterfly (x * 23170 >>> 15, i.e. 1/sqrt2 in Q1.15), plus a 3-qubit instance
// used only to exercise an out-of-range target. Stimulus pushes expected RAM
// events onto a queue; a negedge monitor pops and compares each strobe.
module tb_h_pair_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [0:0]  target;
  logic        busy, done, err, rd_en, wr_en;
  logic [1:0]  rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic [15:0] g_ar, g_ai, g_br, g_bi;
  logic [15:0] g_out0r, g_out0i, g_out1r, g_out1i;

  logic        start1;
  logic [1:0]  target1;
  logic        busy1, done1, err1, rd_en1, wr_en1;
  logic [2:0]  rd_addr1, wr_addr1;
  logic [31:0] wr_data1;
  logic [15:0] g1_ar, g1_ai, g1_br, g1_bi;

  h_pair_sched #(.N_QUBITS(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .g_ar(g_ar), .g_ai(g_ai), .g_br(g_br), .g_bi(g_bi),
    .g_out0r(g_out0r), .g_out0i(g_out0i), .g_out1r(g_out1r), .g_out1i(g_out1i)
  );

  h_pair_sched #(.N_QUBITS(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .target(target1),
    .busy(busy1), .done(done1), .err(err1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(32'h0),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .g_ar(g1_ar), .g_ai(g1_ai), .g_br(g1_br), .g_bi(g1_bi),
    .g_out0r(16'h0), .g_out0i(16'h0), .g_out1r(16'h0), .g_out1i(16'h0)
  );

  int tests = 0, fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference H butterfly, truncating toward -inf.
  function automatic logic [15:0] hs(logic [15:0] x, logic [15:0] y, bit sub);
    int a = $signed(x);
    int b = $signed(y);
    int s = sub ? a - b : a + b;
    int p = s * 23170;
    return 16'(p >>> 15);
  endfunction

  function automatic logic [31:0] hout(logic [31:0] a, logic [31:0] b, bit sub);
    return {hs(a[31:16], b[31:16], sub), hs(a[15:0], b[15:0], sub)};
  endfunction

  always_comb begin
    g_out0r = hs(g_ar, g_br, 1'b0);
    g_out0i = hs(g_ai, g_bi, 1'b0);
    g_out1r = hs(g_ar, g_br, 1'b1);
    g_out1i = hs(g_ai, g_bi, 1'b1);
  end

  // RAM model: one-cycle read latency.
  logic [31:0] ram [4];
  logic [31:0] shadow [4];
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  int cyc = 0, start_cyc = 0, u1_strobes = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rd_en1 || wr_en1) u1_strobes++;

  // kind: 0 read, 1 write, 2 done. rel = cycle number after the start edge.
  typedef struct {
    int          kind;
    int          addr;
    int          rel;
    logic [31:0] data;
    logic [31:0] ga;
    logic [31:0] gb;
    logic        err;
  } ev_t;
  ev_t q[$];

  task automatic push(int kind, int addr, int rel, logic [31:0] d,
                      logic [31:0] ga, logic [31:0] gb, logic e);
    ev_t ev;
    ev.kind = kind; ev.addr = addr; ev.rel = rel;
    ev.data = d; ev.ga = ga; ev.gb = gb; ev.err = e;
    q.push_back(ev);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (err && !done) chk("err_without_done", 1, 0);
    if (rd_en || wr_en || done) begin
      if (q.size() == 0) begin
        chk("spurious_event", {61'd0, rd_en, wr_en, done}, 0);
      end else begin
        ev_t e;
        int  kind, addr;
        e    = q.pop_front();
        kind = rd_en ? 0 : (wr_en ? 1 : 2);
        addr = rd_en ? int'(rd_addr) : (wr_en ? int'(wr_addr) : 0);
        chk("evt_kind", kind, e.kind);
        chk("evt_addr", addr, e.addr);
        chk("evt_cycle", cyc - start_cyc, e.rel);
        if (kind == 1) begin
          chk("wr_data", wr_data, e.data);
          chk("g_a", {g_ar, g_ai}, e.ga);
          chk("g_b", {g_br, g_bi}, e.gb);
        end
        if (kind == 2) begin
          chk("done_err", err, e.err);
          chk("done_busy", busy, 1'b1);
        end
      end
    end
  end

  // Hand-computed pair address orders for N_QUBITS=2: [target][k][i0/i1].
  int pairs [2][2][2] = '{'{'{0, 1}, '{2, 3}}, '{'{0, 2}, '{1, 3}}};

  task automatic push_pass(int t);
    for (int k = 0; k < 2; k++) begin
      int          a0 = pairs[t][k][0];
      int          a1 = pairs[t][k][1];
      logic [31:0] va = shadow[a0];
      logic [31:0] vb = shadow[a1];
      logic [31:0] o0 = hout(va, vb, 1'b0);
      logic [31:0] o1 = hout(va, vb, 1'b1);
      push(0, a0, 5*k+1, 0, 0, 0, 0);
      push(0, a1, 5*k+2, 0, 0, 0, 0);
      push(1, a0, 5*k+4, o0, va, vb, 0);
      push(1, a1, 5*k+5, o1, va, vb, 0);
      shadow[a0] = o0;
      shadow[a1] = o1;
    end
    push(2, 0, 11, 0, 0, 0, 1'b0);
  endtask

  task automatic load_ram(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
    ram[0] = w0; ram[1] = w1; ram[2] = w2; ram[3] = w3;
    shadow[0] = w0; shadow[1] = w1; shadow[2] = w2; shadow[3] = w3;
  endtask

  // Drives start for one cycle; returns at the negedge of the RD0 cycle.
  task automatic do_start(logic t);
    @(negedge clk);
    start = 1'b1; target = t; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; target = '0; start1 = 1'b0; target1 = '0;
    load_ram(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_strobes", {busy, done, err, rd_en, wr_en}, 0);
    chk("reset_addr_data", {rd_addr, wr_addr, wr_data}, 0);
    chk("reset_g", {g_ar, g_ai, g_br, g_bi}, 0);

    // Basic H on qubit 0.
    load_ram(32'h40000000, 0, 0, 0);
    push_pass(0);
    do_start(1'b0);
    wait_drain("basic_pass");
    chk("basic_ram0", ram[0], 32'h2D410000);
    chk("basic_ram1", ram[1], 32'h2D410000);
    chk("basic_ram23", {ram[2], ram[3]}, 0);

    // Pair ordering on qubit 1.
    load_ram(32'h10000000, 32'h20000000, 32'h00001000, 32'hF0000800);
    push_pass(1);
    do_start(1'b1);
    wait_drain("t1_pass");

    // Imaginary / negative path.
    load_ram(32'h0000C000, 32'h00004000, 0, 0);
    push_pass(0);
    do_start(1'b0);
    wait_drain("imag_pass");
    chk("imag_ram0", ram[0], 32'h00000000);
    chk("imag_ram1", ram[1], 32'h0000A57E);

    // Second start during a pass is ignored.
    load_ram(32'h40000000, 0, 0, 0);
    push_pass(0);
    do_start(1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; target = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("busy_start_pass");
    chk("busy_start_ram", {ram[0], ram[1]}, {32'h2D410000, 32'h2D410000});

    // Reset during the first WR0; that write still lands.
    load_ram(32'h40000000, 32'h20000000, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push(0, 1, 2, 0, 0, 0, 0);
    push(1, 0, 4, hout(shadow[0], shadow[1], 1'b0), shadow[0], shadow[1], 0);
    shadow[0] = hout(shadow[0], shadow[1], 1'b0);
    do_start(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_idle", {busy, wr_en, rd_en, done}, 0);
    chk("rst_mid_drained", q.size(), 0);
    rst = 1'b0;
    push_pass(0);
    do_start(1'b0);
    wait_drain("after_rst_pass");

    // Out-of-range target on the 3-qubit instance.
    @(negedge clk);
    start1 = 1'b1; target1 = 2'd3;
    @(negedge clk);
    start1 = 1'b0;
    chk("inv_done_err_busy", {done1, err1, busy1}, 3'b111);
    @(negedge clk);
    chk("inv_after", {done1, err1, busy1}, 3'b000);
    chk("inv_no_ram", u1_strobes, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
